// File: rtl/cache_meta_pkg.sv
// Shared types and constants for the cache tag store: flush FSM states,
// replacement policy selectors and the victim metadata packing helper.
package cache_meta_pkg;

   typedef enum logic [1:0] {StIdle, StScan, StWb, StDone} flush_state_e;

   localparam int unsigned REPL_PLRU = 0;
   localparam int unsigned REPL_RR   = 1;

   typedef struct packed {
      logic valid;
      logic dirty;
   } victim_meta_t;

   // Read-only caches never report a dirty victim.
   function automatic victim_meta_t pack_victim(input logic valid, input logic dirty,
                                                input logic read_only);
      victim_meta_t m;
      m.valid = valid;
      m.dirty = dirty & ~read_only;
      return m;
   endfunction

endpackage

// File: rtl/plru_tree.sv
// Per-set tree-PLRU state. Node n has children 2n+1 (lower ways) and 2n+2;
// a node bit of 0 points the victim search toward the lower half.
module plru_tree #(
   parameter int unsigned NUM_SETS = 4,
   parameter int unsigned ASSOC    = 4,
   localparam int unsigned SET_W   = $clog2(NUM_SETS),
   localparam int unsigned WAY_W   = (ASSOC > 1) ? $clog2(ASSOC) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             touch_a_en,
   input  logic [SET_W-1:0] touch_a_set,
   input  logic [WAY_W-1:0] touch_a_way,
   input  logic             touch_b_en,
   input  logic [SET_W-1:0] touch_b_set,
   input  logic [WAY_W-1:0] touch_b_way,
   input  logic [SET_W-1:0] query_set,
   output logic [WAY_W-1:0] victim_way
);

   localparam int unsigned LEVELS = $clog2(ASSOC);
   localparam int unsigned NODES  = (ASSOC > 1) ? ASSOC - 1 : 1;

   logic [NODES-1:0] bits_q [NUM_SETS];
   logic [NODES-1:0] bits_d [NUM_SETS];

   function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] b,
                                              input logic [WAY_W-1:0] way);
      logic [NODES-1:0] r;
      int unsigned      node;
      logic             dir;
      r    = b;
      node = 0;
      for (int l = 0; l < int'(LEVELS); l++) begin
         dir     = way[int'(LEVELS) - 1 - l];
         r[node] = ~dir;
         node    = 2 * node + 1 + 32'(dir);
      end
      return r;
   endfunction

   function automatic logic [WAY_W-1:0] victim_of(input logic [NODES-1:0] b);
      logic [WAY_W-1:0] w;
      int unsigned      node;
      w    = '0;
      node = 0;
      for (int l = 0; l < int'(LEVELS); l++) begin
         w    = (w << 1) | WAY_W'(b[node]);
         node = 2 * node + 1 + 32'(b[node]);
      end
      return w;
   endfunction

   // Install is applied after the lookup touch so it has the final say.
   always_comb begin
      bits_d = bits_q;
      if (touch_a_en) bits_d[touch_a_set] = touch(bits_d[touch_a_set], touch_a_way);
      if (touch_b_en) bits_d[touch_b_set] = touch(bits_d[touch_b_set], touch_b_way);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < int'(NUM_SETS); s++) bits_q[s] <= '0;
      end else begin
         bits_q <= bits_d;
      end
   end

   assign victim_way = victim_of(bits_q[query_set]);

endmodule

// File: rtl/cache_tag_store.sv
// Tag/valid/dirty metadata for an N-way set-associative cache with registered
// lookup, victim selection and a write-back flush walker.
module cache_tag_store import cache_meta_pkg::*; #(
   parameter int unsigned NUM_SETS    = 4,
   parameter int unsigned ASSOC       = 4,
   parameter int unsigned TAG_SIZE    = 30,
   parameter bit          READ_ONLY   = 1'b0,
   parameter int unsigned REPL_POLICY = REPL_PLRU,
   localparam int unsigned SET_W      = $clog2(NUM_SETS),
   localparam int unsigned WAY_W      = (ASSOC > 1) ? $clog2(ASSOC) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                lookup_valid,
   output logic                lookup_ready,
   input  logic [SET_W-1:0]    lookup_set,
   input  logic [TAG_SIZE-1:0] lookup_tag,
   input  logic                lookup_touch,
   output logic                rsp_valid,
   output logic                rsp_hit,
   output logic [WAY_W-1:0]    rsp_way,
   output logic [WAY_W-1:0]    rsp_victim_way,
   output logic                rsp_victim_valid,
   output logic                rsp_victim_dirty,
   output logic [TAG_SIZE-1:0] rsp_victim_tag,
   input  logic                install_en,
   input  logic [SET_W-1:0]    install_set,
   input  logic [WAY_W-1:0]    install_way,
   input  logic [TAG_SIZE-1:0] install_tag,
   input  logic                install_dirty,
   input  logic                mark_dirty_en,
   input  logic [SET_W-1:0]    mark_dirty_set,
   input  logic [WAY_W-1:0]    mark_dirty_way,
   input  logic                flush_req,
   output logic                busy,
   output logic                wb_valid,
   input  logic                wb_ready,
   output logic [SET_W-1:0]    wb_set,
   output logic [WAY_W-1:0]    wb_way,
   output logic [TAG_SIZE-1:0] wb_tag,
   output logic                flush_done
);

   localparam int unsigned ENTRIES = NUM_SETS * ASSOC;
   localparam int unsigned ENT_W   = $clog2(ENTRIES);
   localparam int unsigned WAY_SH  = $clog2(ASSOC);

   function automatic logic [ENT_W-1:0] ent_idx(input logic [SET_W-1:0] s,
                                                input logic [WAY_W-1:0] w);
      return ENT_W'(s) * ENT_W'(ASSOC) + ENT_W'(w);
   endfunction

   logic [TAG_SIZE-1:0] tag_q [ENTRIES];
   logic [ENTRIES-1:0]  valid_q, dirty_q;

   flush_state_e        state_q;
   logic [ENT_W-1:0]    idx_q;
   logic                busy_q, wb_valid_q, flush_done_q;
   logic [SET_W-1:0]    wb_set_q;
   logic [WAY_W-1:0]    wb_way_q;
   logic [TAG_SIZE-1:0] wb_tag_q;

   logic                rsp_valid_q, rsp_hit_q, rsp_victim_valid_q, rsp_victim_dirty_q;
   logic [WAY_W-1:0]    rsp_way_q, rsp_victim_way_q;
   logic [TAG_SIZE-1:0] rsp_victim_tag_q;

   logic                accept, upd_ok, any_invalid;
   logic [ASSOC-1:0]    hit_vec, set_valid;
   logic [WAY_W-1:0]    hit_way, inv_way, policy_way, victim_way;
   logic [ENT_W-1:0]    victim_e, install_e, mark_e;
   victim_meta_t        victim_meta;

   assign accept    = lookup_valid && !busy_q;
   assign upd_ok    = !busy_q;
   assign install_e = ent_idx(install_set, install_way);
   assign mark_e    = ent_idx(mark_dirty_set, mark_dirty_way);

   always_comb begin
      hit_vec     = '0;
      set_valid   = '0;
      hit_way     = '0;
      inv_way     = '0;
      any_invalid = 1'b0;
      for (int w = 0; w < int'(ASSOC); w++) begin
         set_valid[w] = valid_q[ent_idx(lookup_set, WAY_W'(w))];
         hit_vec[w]   = set_valid[w] && (tag_q[ent_idx(lookup_set, WAY_W'(w))] == lookup_tag);
         if (hit_vec[w]) hit_way = WAY_W'(w);
      end
      // Descending scan so the lowest invalid way is the one that sticks.
      for (int w = int'(ASSOC) - 1; w >= 0; w--) begin
         if (!set_valid[w]) begin
            any_invalid = 1'b1;
            inv_way     = WAY_W'(w);
         end
      end
   end

   assign victim_way  = any_invalid ? inv_way : policy_way;
   assign victim_e    = ent_idx(lookup_set, victim_way);
   assign victim_meta = pack_victim(valid_q[victim_e], dirty_q[victim_e], READ_ONLY);

   generate
      if (REPL_POLICY == REPL_PLRU) begin : g_plru
         plru_tree #(
            .NUM_SETS (NUM_SETS),
            .ASSOC    (ASSOC)
         ) u_plru (
            .clk         (clk),
            .reset       (reset),
            .touch_a_en  (accept && lookup_touch && (|hit_vec)),
            .touch_a_set (lookup_set),
            .touch_a_way (hit_way),
            .touch_b_en  (install_en && upd_ok),
            .touch_b_set (install_set),
            .touch_b_way (install_way),
            .query_set   (lookup_set),
            .victim_way  (policy_way)
         );
      end else begin : g_rr
         logic [WAY_W-1:0] rr_q [NUM_SETS];
         always_ff @(posedge clk) begin
            if (reset) begin
               for (int s = 0; s < int'(NUM_SETS); s++) rr_q[s] <= '0;
            end else if (install_en && upd_ok && (install_way == rr_q[install_set])) begin
               rr_q[install_set] <= (rr_q[install_set] == WAY_W'(ASSOC - 1)) ? '0
                                    : rr_q[install_set] + 1'b1;
            end
         end
         assign policy_way = rr_q[lookup_set];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q        <= 1'b0;
         rsp_hit_q          <= 1'b0;
         rsp_way_q          <= '0;
         rsp_victim_way_q   <= '0;
         rsp_victim_valid_q <= 1'b0;
         rsp_victim_dirty_q <= 1'b0;
         rsp_victim_tag_q   <= '0;
      end else begin
         rsp_valid_q <= accept;
         if (accept) begin
            rsp_hit_q          <= |hit_vec;
            rsp_way_q          <= hit_way;
            rsp_victim_way_q   <= victim_way;
            rsp_victim_valid_q <= victim_meta.valid;
            rsp_victim_dirty_q <= victim_meta.dirty;
            rsp_victim_tag_q   <= tag_q[victim_e];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (install_en && upd_ok) tag_q[install_e] <= install_tag;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         valid_q      <= '0;
         dirty_q      <= '0;
         busy_q       <= 1'b0;
         wb_valid_q   <= 1'b0;
         flush_done_q <= 1'b0;
         wb_set_q     <= '0;
         wb_way_q     <= '0;
         wb_tag_q     <= '0;
      end else begin
         flush_done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // mark_dirty first so a colliding install overrides it.
               if (mark_dirty_en && !READ_ONLY && valid_q[mark_e]) dirty_q[mark_e] <= 1'b1;
               if (install_en) begin
                  valid_q[install_e] <= 1'b1;
                  dirty_q[install_e] <= install_dirty & !READ_ONLY;
               end
               if (flush_req) begin
                  state_q <= StScan;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            StScan: begin
               if (valid_q[idx_q] && dirty_q[idx_q]) begin
                  state_q    <= StWb;
                  wb_valid_q <= 1'b1;
                  wb_set_q   <= SET_W'(idx_q >> WAY_SH);
                  wb_way_q   <= WAY_W'(idx_q & ENT_W'(ASSOC - 1));
                  wb_tag_q   <= tag_q[idx_q];
               end else begin
                  valid_q[idx_q] <= 1'b0;
                  dirty_q[idx_q] <= 1'b0;
                  if (idx_q == ENT_W'(ENTRIES - 1)) begin
                     state_q      <= StDone;
                     flush_done_q <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            StWb: begin
               if (wb_ready) begin
                  valid_q[idx_q] <= 1'b0;
                  dirty_q[idx_q] <= 1'b0;
                  wb_valid_q     <= 1'b0;
                  if (idx_q == ENT_W'(ENTRIES - 1)) begin
                     state_q      <= StDone;
                     flush_done_q <= 1'b1;
                  end else begin
                     state_q <= StScan;
                     idx_q   <= idx_q + 1'b1;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   a_one_hit: assert property (@(posedge clk) disable iff (reset) accept |-> $onehot0(hit_vec));

   assign lookup_ready     = !busy_q;
   assign busy             = busy_q;
   assign rsp_valid        = rsp_valid_q;
   assign rsp_hit          = rsp_hit_q;
   assign rsp_way          = rsp_way_q;
   assign rsp_victim_way   = rsp_victim_way_q;
   assign rsp_victim_valid = rsp_victim_valid_q;
   assign rsp_victim_dirty = rsp_victim_dirty_q;
   assign rsp_victim_tag   = rsp_victim_tag_q;
   assign wb_valid         = wb_valid_q;
   assign wb_set           = wb_set_q;
   assign wb_way           = wb_way_q;
   assign wb_tag           = wb_tag_q;
   assign flush_done       = flush_done_q;

endmodule

// File: tb/tb_cache_tag_store.sv
// Directed bench: default PLRU store (d_*) and a READ_ONLY round-robin store (a_*)
// driven from shared inputs.
module tb_cache_tag_store;

   logic        clk = 1'b0;
   logic        reset;
   logic        lookup_valid, lookup_touch;
   logic [1:0]  lookup_set;
   logic [29:0] lookup_tag;
   logic        install_en, install_dirty;
   logic [1:0]  install_set, install_way;
   logic [29:0] install_tag;
   logic        mark_dirty_en;
   logic [1:0]  mark_dirty_set, mark_dirty_way;
   logic        flush_req, wb_ready;

   logic        d_lookup_ready, d_rsp_valid, d_rsp_hit, d_rsp_victim_valid, d_rsp_victim_dirty;
   logic [1:0]  d_rsp_way, d_rsp_victim_way, d_wb_set, d_wb_way;
   logic [29:0] d_rsp_victim_tag, d_wb_tag;
   logic        d_busy, d_wb_valid, d_flush_done;

   logic        a_lookup_ready, a_rsp_valid, a_rsp_hit, a_rsp_victim_valid, a_rsp_victim_dirty;
   logic [1:0]  a_rsp_way, a_rsp_victim_way, a_wb_set, a_wb_way;
   logic [29:0] a_rsp_victim_tag, a_wb_tag;
   logic        a_busy, a_wb_valid, a_flush_done;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cache_tag_store u_dut (
      .clk(clk), .reset(reset),
      .lookup_valid(lookup_valid), .lookup_ready(d_lookup_ready),
      .lookup_set(lookup_set), .lookup_tag(lookup_tag), .lookup_touch(lookup_touch),
      .rsp_valid(d_rsp_valid), .rsp_hit(d_rsp_hit), .rsp_way(d_rsp_way),
      .rsp_victim_way(d_rsp_victim_way), .rsp_victim_valid(d_rsp_victim_valid),
      .rsp_victim_dirty(d_rsp_victim_dirty), .rsp_victim_tag(d_rsp_victim_tag),
      .install_en(install_en), .install_set(install_set), .install_way(install_way),
      .install_tag(install_tag), .install_dirty(install_dirty),
      .mark_dirty_en(mark_dirty_en), .mark_dirty_set(mark_dirty_set),
      .mark_dirty_way(mark_dirty_way),
      .flush_req(flush_req), .busy(d_busy), .wb_valid(d_wb_valid), .wb_ready(wb_ready),
      .wb_set(d_wb_set), .wb_way(d_wb_way), .wb_tag(d_wb_tag), .flush_done(d_flush_done)
   );

   cache_tag_store #(.READ_ONLY(1'b1), .REPL_POLICY(1)) u_alt (
      .clk(clk), .reset(reset),
      .lookup_valid(lookup_valid), .lookup_ready(a_lookup_ready),
      .lookup_set(lookup_set), .lookup_tag(lookup_tag), .lookup_touch(lookup_touch),
      .rsp_valid(a_rsp_valid), .rsp_hit(a_rsp_hit), .rsp_way(a_rsp_way),
      .rsp_victim_way(a_rsp_victim_way), .rsp_victim_valid(a_rsp_victim_valid),
      .rsp_victim_dirty(a_rsp_victim_dirty), .rsp_victim_tag(a_rsp_victim_tag),
      .install_en(install_en), .install_set(install_set), .install_way(install_way),
      .install_tag(install_tag), .install_dirty(install_dirty),
      .mark_dirty_en(mark_dirty_en), .mark_dirty_set(mark_dirty_set),
      .mark_dirty_way(mark_dirty_way),
      .flush_req(flush_req), .busy(a_busy), .wb_valid(a_wb_valid), .wb_ready(wb_ready),
      .wb_set(a_wb_set), .wb_way(a_wb_way), .wb_tag(a_wb_tag), .flush_done(a_flush_done)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      lookup_valid = 1'b0; lookup_touch = 1'b0; lookup_set = '0; lookup_tag = '0;
      install_en = 1'b0; install_dirty = 1'b0; install_set = '0; install_way = '0;
      install_tag = '0; mark_dirty_en = 1'b0; mark_dirty_set = '0; mark_dirty_way = '0;
      flush_req = 1'b0; wb_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic install(input logic [1:0] s, input logic [1:0] w, input logic [29:0] t,
                          input logic d);
      install_en = 1'b1; install_set = s; install_way = w; install_tag = t; install_dirty = d;
      tick();
      install_en = 1'b0;
   endtask

   task automatic lookup(input logic [1:0] s, input logic [29:0] t, input logic touch);
      lookup_valid = 1'b1; lookup_set = s; lookup_tag = t; lookup_touch = touch;
      tick();
      lookup_valid = 1'b0; lookup_touch = 1'b0;
   endtask

   initial begin
      int n01, n33, nother, ndone, done_cycle, wb_seen;
      logic finished, reached;
      logic [29:0] tag01, tag33;

      // Reset state and first lookup on an empty cache
      do_reset();
      check("reset_busy", d_busy, 0);
      check("reset_ready", d_lookup_ready, 1);
      check("reset_rsp_valid", d_rsp_valid, 0);
      check("reset_wb_valid", d_wb_valid, 0);
      check("reset_flush_done", d_flush_done, 0);
      lookup(2'd2, 30'h15, 1'b0);
      check("empty_rsp_valid", d_rsp_valid, 1);
      check("empty_hit", d_rsp_hit, 0);
      check("empty_victim_way", d_rsp_victim_way, 0);
      check("empty_victim_valid", d_rsp_victim_valid, 0);
      tick();
      check("rsp_valid_drops", d_rsp_valid, 0);

      // PLRU: fill set 1, touch ways 0 and 2, victim must be way 1
      for (int w = 0; w < 4; w++) install(2'd1, 2'(w), 30'hA0 + 30'(w), 1'b0);
      lookup(2'd1, 30'hA0, 1'b1);
      check("hit_a0", d_rsp_hit, 1);
      check("hit_a0_way", d_rsp_way, 0);
      lookup(2'd1, 30'hA2, 1'b1);
      check("hit_a2", d_rsp_hit, 1);
      check("hit_a2_way", d_rsp_way, 2);
      lookup(2'd1, 30'hFF, 1'b0);
      check("miss_ff", d_rsp_hit, 0);
      check("miss_way_zero", d_rsp_way, 0);
      check("plru_victim_way", d_rsp_victim_way, 1);
      check("plru_victim_valid", d_rsp_victim_valid, 1);
      check("plru_victim_tag", d_rsp_victim_tag, 30'hA1);
      check("plru_victim_dirty", d_rsp_victim_dirty, 0);

      // Lookup in the same cycle as an install to that set sees the old contents
      lookup_valid = 1'b1; lookup_set = 2'd1; lookup_tag = 30'hB0; lookup_touch = 1'b0;
      install_en = 1'b1; install_set = 2'd1; install_way = 2'd1; install_tag = 30'hB0;
      install_dirty = 1'b0;
      tick();
      lookup_valid = 1'b0; install_en = 1'b0;
      check("same_cycle_pre_install", d_rsp_hit, 0);
      lookup(2'd1, 30'hB0, 1'b0);
      check("post_install_hit", d_rsp_hit, 1);
      check("post_install_way", d_rsp_way, 1);

      // Flush with two dirty lines and a stalled write-back
      do_reset();
      install(2'd0, 2'd1, 30'h11, 1'b1);
      install(2'd3, 2'd3, 30'h33, 1'b0);
      mark_dirty_en = 1'b1; mark_dirty_set = 2'd3; mark_dirty_way = 2'd3;
      tick();
      mark_dirty_set = 2'd2; mark_dirty_way = 2'd0;  // invalid line: must stay clean
      tick();
      mark_dirty_en = 1'b0;
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      check("flush_busy", d_busy, 1);
      check("flush_not_ready", d_lookup_ready, 0);
      n01 = 0; n33 = 0; nother = 0; ndone = 0; finished = 1'b0; tag01 = '0; tag33 = '0;
      for (int c = 0; c < 60 && !finished; c++) begin
         if (d_wb_valid) begin
            if (d_wb_set == 2'd0 && d_wb_way == 2'd1) begin
               n01++; tag01 = d_wb_tag;
            end else if (d_wb_set == 2'd3 && d_wb_way == 2'd3) begin
               n33++; tag33 = d_wb_tag;
            end else begin
               nother++;
            end
         end
         if (d_flush_done) ndone++;
         if (ndone > 0 && !d_busy) finished = 1'b1;
         wb_ready = !(d_wb_valid && d_wb_set == 2'd0 && d_wb_way == 2'd1 && n01 < 4);
         tick();
      end
      wb_ready = 1'b0;
      check("flush_finished", finished, 1);
      check("wb01_held_cycles", n01, 4);
      check("wb01_tag", tag01, 30'h11);
      check("wb33_cycles", n33, 1);
      check("wb33_tag", tag33, 30'h33);
      check("wb_other", nother, 0);
      check("flush_done_once", ndone, 1);
      lookup(2'd0, 30'h11, 1'b0);
      check("post_flush_miss01", d_rsp_hit, 0);
      check("post_flush_victim01", d_rsp_victim_valid, 0);
      lookup(2'd3, 30'h33, 1'b0);
      check("post_flush_miss33", d_rsp_hit, 0);
      lookup(2'd1, 30'h0, 1'b0);
      check("post_flush_miss_s1", d_rsp_hit, 0);

      // READ_ONLY store: all lines valid, flush never writes back, done at cycle 17
      do_reset();
      for (int i = 0; i < 16; i++) install(2'(i / 4), 2'(i % 4), 30'h100 + 30'(i), 1'b1);
      lookup(2'd2, 30'h10A, 1'b0);
      check("ro_hit", a_rsp_hit, 1);
      check("ro_hit_way", a_rsp_way, 2);
      check("ro_victim_clean", a_rsp_victim_dirty, 0);
      wb_ready = 1'b1;
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      done_cycle = 0; wb_seen = 0; ndone = 0;
      for (int c = 1; c <= 20; c++) begin
         if (a_flush_done) begin
            ndone++;
            if (done_cycle == 0) done_cycle = c;
         end
         if (a_wb_valid) wb_seen = 1;
         tick();
      end
      check("ro_done_cycle", done_cycle, 17);
      check("ro_done_once", ndone, 1);
      check("ro_no_wb", wb_seen, 0);
      lookup(2'd2, 30'h10A, 1'b0);
      check("ro_post_flush_miss", a_rsp_hit, 0);

      // Reset during a stalled write-back
      do_reset();
      install(2'd2, 2'd0, 30'h22, 1'b1);
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      reached = 1'b0;
      for (int c = 0; c < 20 && !reached; c++) begin
         if (d_wb_valid) reached = 1'b1;
         else tick();
      end
      check("midflush_wb_reached", reached, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midflush_busy", d_busy, 0);
      check("midflush_wb_valid", d_wb_valid, 0);
      ndone = 0;
      for (int c = 0; c < 20; c++) begin
         if (d_flush_done) ndone++;
         tick();
      end
      check("midflush_no_done", ndone, 0);
      lookup(2'd2, 30'h22, 1'b0);
      check("midflush_line_gone", d_rsp_hit, 0);
      check("midflush_victim_invalid", d_rsp_victim_valid, 0);

      // Round-robin pointer on the alternate store
      do_reset();
      for (int i = 0; i < 4; i++) begin
         lookup(2'd2, 30'h3FF, 1'b0);
         check("rr_victim_fill", a_rsp_victim_way, i);
         install(2'd2, 2'(i), 30'h40 + 30'(i), 1'b0);
      end
      lookup(2'd2, 30'h3FF, 1'b0);
      check("rr_wrap_way", a_rsp_victim_way, 0);
      check("rr_wrap_valid", a_rsp_victim_valid, 1);
      check("rr_wrap_tag", a_rsp_victim_tag, 30'h40);
      install(2'd2, 2'd0, 30'h50, 1'b0);
      lookup(2'd2, 30'h3FF, 1'b0);
      check("rr_advance", a_rsp_victim_way, 1);
      install(2'd2, 2'd3, 30'h53, 1'b0);
      lookup(2'd2, 30'h3FF, 1'b0);
      check("rr_hold_off_pointer", a_rsp_victim_way, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
